// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the timer control block.
// Contents: FSM state enum, register addresses, CTRL bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } tmr_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESC  = 2'd1;
  localparam logic [1:0] ADDR_RELOAD = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_AUTO     = 2;
  localparam int CTRL_EDGE     = 3;
  localparam int CTRL_IRQ_CLR  = 4;
  localparam int CTRL_IRQ_EN   = 5;
  localparam int CTRL_IRQ_FLAG = 6;
  localparam int CTRL_STATE    = 8;

endpackage

// File: rtl/timer_ctrl_if.sv
// Register port of the timer control block.
//  cfg_we_i    write strobe
//  cfg_addr_i  register address
//  cfg_wdata_i write data
//  cfg_rdata_o registered read data
interface timer_ctrl_if;
  logic        cfg_we_i;
  logic [1:0]  cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic [31:0] cfg_rdata_o;

  modport master (output cfg_we_i, cfg_addr_i, cfg_wdata_i, input cfg_rdata_o);
  modport slave  (input cfg_we_i, cfg_addr_i, cfg_wdata_i, output cfg_rdata_o);
endinterface

// File: rtl/timer_ctrl_regs.sv
// Configuration register file for the timer control block.
//  cfg          register port (slave side); drives registered read data
//  state/irq_flag/count  live status folded into reads
//  start/stop/irq_clr    one-cycle command pulses decoded from CTRL writes
//  auto_reload/edge_mode/irq_en/prescaler/reload  held configuration
//  src_rst      registered divisor-restart request after PRESC or edge change
module timer_ctrl_regs
  import timer_pkg::*;
#(
  parameter int COUNTER_SIZE  = 32,
  parameter int PRESCALER_BIT = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  timer_ctrl_if.slave              cfg,
  input  tmr_state_e               state,
  input  logic                     irq_flag,
  input  logic [COUNTER_SIZE-1:0]  count,
  output logic                     start,
  output logic                     stop,
  output logic                     irq_clr,
  output logic                     auto_reload,
  output logic                     edge_mode,
  output logic                     irq_en,
  output logic [PRESCALER_BIT-1:0] prescaler,
  output logic [COUNTER_SIZE-1:0]  reload,
  output logic                     src_rst
);

  logic        wr_ctrl, wr_presc, wr_reload;
  logic [31:0] rd_mux;

  assign wr_ctrl   = cfg.cfg_we_i && (cfg.cfg_addr_i == ADDR_CTRL);
  assign wr_presc  = cfg.cfg_we_i && (cfg.cfg_addr_i == ADDR_PRESC);
  assign wr_reload = cfg.cfg_we_i && (cfg.cfg_addr_i == ADDR_RELOAD);

  assign start   = wr_ctrl && cfg.cfg_wdata_i[CTRL_START];
  assign stop    = wr_ctrl && cfg.cfg_wdata_i[CTRL_STOP];
  assign irq_clr = wr_ctrl && cfg.cfg_wdata_i[CTRL_IRQ_CLR];

  always_comb begin
    rd_mux = '0;
    case (cfg.cfg_addr_i)
      ADDR_CTRL: begin
        rd_mux[CTRL_AUTO]         = auto_reload;
        rd_mux[CTRL_EDGE]         = edge_mode;
        rd_mux[CTRL_IRQ_EN]       = irq_en;
        rd_mux[CTRL_IRQ_FLAG]     = irq_flag;
        rd_mux[CTRL_STATE +: 2]   = state;
      end
      ADDR_PRESC:  rd_mux[PRESCALER_BIT-1:0] = prescaler;
      ADDR_RELOAD: rd_mux[COUNTER_SIZE-1:0]  = reload;
      default:     rd_mux[COUNTER_SIZE-1:0]  = count;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      auto_reload     <= 1'b0;
      edge_mode       <= 1'b0;
      irq_en          <= 1'b0;
      prescaler       <= '0;
      reload          <= '0;
      src_rst         <= 1'b0;
      cfg.cfg_rdata_o <= '0;
    end else begin
      // Restart the divisor only when its inputs actually change meaning.
      src_rst         <= wr_presc || (wr_ctrl && (cfg.cfg_wdata_i[CTRL_EDGE] != edge_mode));
      cfg.cfg_rdata_o <= rd_mux;
      if (wr_ctrl) begin
        auto_reload <= cfg.cfg_wdata_i[CTRL_AUTO];
        edge_mode   <= cfg.cfg_wdata_i[CTRL_EDGE];
        irq_en      <= cfg.cfg_wdata_i[CTRL_IRQ_EN];
      end
      if (wr_presc)  prescaler <= cfg.cfg_wdata_i[PRESCALER_BIT-1:0];
      if (wr_reload) reload    <= cfg.cfg_wdata_i[COUNTER_SIZE-1:0];
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer control/sequencing unit: FSM, tick counter, compare, irq flag.
//  clk_i/rst_ni  clock, async active-low reset
//  cfg           register port (CTRL/PRESC/RELOAD/COUNT)
//  tick_i        one-cycle strobe from the input block
//  prescaler_o/edge_mode_o/src_rst_o  configuration to the input block
//  count_o       main counter; busy_o in ARM/RUN; irq_o = flag & enable
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int COUNTER_SIZE  = 32,
  parameter int PRESCALER_BIT = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  timer_ctrl_if.slave              cfg,
  input  logic                     tick_i,
  output logic [PRESCALER_BIT-1:0] prescaler_o,
  output logic                     edge_mode_o,
  output logic                     src_rst_o,
  output logic [COUNTER_SIZE-1:0]  count_o,
  output logic                     busy_o,
  output logic                     irq_o
);

  tmr_state_e                state_q, state_d;
  logic [COUNTER_SIZE-1:0]   count_q, reload;
  logic                      irq_flag_q;
  logic                      start, stop, irq_clr, auto_reload, irq_en, src_rst_q;
  logic                      tick_ok, match, hit;

  timer_ctrl_regs #(
    .COUNTER_SIZE  (COUNTER_SIZE),
    .PRESCALER_BIT (PRESCALER_BIT)
  ) u_regs (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cfg         (cfg),
    .state       (state_q),
    .irq_flag    (irq_flag_q),
    .count       (count_q),
    .start       (start),
    .stop        (stop),
    .irq_clr     (irq_clr),
    .auto_reload (auto_reload),
    .edge_mode   (edge_mode_o),
    .irq_en      (irq_en),
    .prescaler   (prescaler_o),
    .reload      (reload),
    .src_rst     (src_rst_q)
  );

  // A tick only counts in RUN when no command claims the same cycle.
  assign tick_ok = (state_q == RUN) && tick_i && !start && !stop;
  // >= rather than == so a reload lowered below count still matches.
  assign match   = (count_q >= reload);
  assign hit     = tick_ok && match;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !stop) state_d = ARM;
      ARM:  state_d = stop ? IDLE : (start ? ARM : RUN);
      RUN: begin
        if (stop)                     state_d = IDLE;
        else if (start)               state_d = ARM;
        else if (hit && !auto_reload) state_d = DONE;
      end
      DONE: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = ARM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ARM)                 count_q <= '0;
      else if (tick_ok && !match)         count_q <= count_q + 1'b1;
      else if (tick_ok && auto_reload)    count_q <= '0;
      if (hit)          irq_flag_q <= 1'b1;
      else if (irq_clr) irq_flag_q <= 1'b0;
    end
  end

  assign src_rst_o = src_rst_q || (state_q == ARM);
  assign count_o   = count_q;
  assign busy_o    = (state_q == ARM) || (state_q == RUN);
  assign irq_o     = irq_flag_q && irq_en;

endmodule
